alu_issue_ctrl: RTL and testbench

//  Issue-side controller that drives the registered MIPS ALU and consumes its result.

---
 rtl/alu_issue_ctrl_if.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and result channels of the ALU issue controller.
interface alu_issue_ctrl_if #(parameter int DW = 32, parameter int RW = 5);
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_opcode;
    logic [5:0]    in_funct;
    logic [4:0]    in_shamt;
    logic [DW-1:0] in_rs_val;
    logic [DW-1:0] in_rt_val;
    logic [15:0]   in_imm;
    logic [RW-1:0] in_dest;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_csig;
    logic [DW-1:0] alu_out;
    logic          alu_z;
    logic          alu_n;
    logic          alu_v;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [RW-1:0] res_dest;
    logic          res_z;
    logic          res_n;
    logic          res_v;
    logic          res_err;

    modport slave (
        input  in_valid, in_opcode, in_funct, in_shamt, in_rs_val, in_rt_val, in_imm, in_dest,
        output in_ready,
        output alu_a, alu_b, alu_csig,
        input  alu_out, alu_z, alu_n, alu_v,
        output res_valid, res_data, res_dest, res_z, res_n, res_v, res_err,
        input  res_ready
    );

    modport master (
        output in_valid, in_opcode, in_funct, in_shamt, in_rs_val, in_rt_val, in_imm, in_dest,
        input  in_ready,
        input  alu_a, alu_b, alu_csig,
        output alu_out, alu_z, alu_n, alu_v,
        input  res_valid, res_data, res_dest, res_z, res_n, res_v, res_err,
        output res_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one MIPS instruction, issues it to the registered ALU and returns the result.
module alu_issue_ctrl #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic clk,
    input logic rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [3:0] C_OR = 4'b0000, C_AND = 4'b0001, C_XOR = 4'b0010, C_SLL = 4'b0011;
    localparam logic [3:0] C_SRL = 4'b0100, C_SUB = 4'b0101, C_ADD = 4'b0110, C_NOR = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1001, C_MUL = 4'b1010, C_CLR = 4'b1011, C_LWSW = 4'b1101;
    localparam logic [3:0] C_SRA = 4'b1110;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state, nxt;

    logic          ok;
    logic [3:0]    cs;
    logic [DW-1:0] a, b, sext, zext, sh;
    logic          accept;

    assign sext   = {{(DW-16){bus.in_imm[15]}}, bus.in_imm};
    assign zext   = {{(DW-16){1'b0}}, bus.in_imm};
    assign sh     = {{(DW-5){1'b0}}, bus.in_shamt};
    assign accept = state == IDLE && bus.in_valid;

    always_comb begin
        ok = 1'b1;
        cs = C_CLR;
        a  = bus.in_rs_val;
        b  = bus.in_rt_val;
        case (bus.in_opcode)
            6'h00: case (bus.in_funct)
                6'h20: cs = C_ADD;
                6'h22: cs = C_SUB;
                6'h24: cs = C_AND;
                6'h25: cs = C_OR;
                6'h26: cs = C_XOR;
                6'h27: cs = C_NOR;
                6'h2A: cs = C_SLT;
                6'h00: begin cs = C_SLL; a = bus.in_rt_val; b = sh; end
                6'h02: begin cs = C_SRL; a = bus.in_rt_val; b = sh; end
                6'h03: begin cs = C_SRA; a = bus.in_rt_val; b = sh; end
                default: ok = 1'b0;
            endcase
            6'h1C: begin cs = C_MUL; ok = bus.in_funct == 6'h02; end
            6'h08: begin cs = C_ADD; b = sext; end
            6'h0A: begin cs = C_SLT; b = sext; end
            6'h0C: begin cs = C_AND; b = zext; end
            6'h0D: begin cs = C_OR;  b = zext; end
            6'h0E: begin cs = C_XOR; b = zext; end
            // the ALU adds b>>1 for loads/stores, so pre-double the offset
            6'h23, 6'h2B: begin cs = C_LWSW; b = sext << 1; end
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.in_valid ? (ok ? ISSUE : RESP) : IDLE;
            ISSUE:   nxt = CAPTURE;
            CAPTURE: nxt = RESP;
            RESP:    nxt = bus.res_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.res_valid = state == RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_csig <= C_CLR;
            bus.res_data <= '0;
            bus.res_dest <= '0;
            bus.res_z    <= 1'b0;
            bus.res_n    <= 1'b0;
            bus.res_v    <= 1'b0;
            bus.res_err  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                bus.res_dest <= RW'(bus.in_dest);
                bus.res_err  <= !ok;
                if (ok) begin
                    bus.alu_a    <= a;
                    bus.alu_b    <= b;
                    bus.alu_csig <= cs;
                end else begin
                    bus.res_data <= '0;
                    bus.res_z    <= 1'b0;
                    bus.res_n    <= 1'b0;
                    bus.res_v    <= 1'b0;
                end
            end
            // z/n follow the operands combinationally; out/v appear one edge later
            if (state == ISSUE) begin
                bus.res_z <= bus.alu_z;
                bus.res_n <= bus.alu_n;
            end
            if (state == CAPTURE) begin
                bus.res_data <= bus.alu_out;
                bus.res_v    <= bus.alu_v;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table, corner sequences and random ops against a MIPS-level reference model.
module tb_alu_issue_ctrl;
    logic clk = 0;
    logic rst_n = 1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(32), .RW(5)) bus ();
    alu_issue_ctrl #(.DW(32), .RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  dest;
    } op_t;

    typedef struct {
        op_t         o;
        logic [31:0] exp_data;
        logic        exp_z;
        logic        exp_err;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] iss_a, iss_b, pre_a, pre_b;
    logic [3:0]  iss_cs, pre_cs;
    logic [31:0] alu_c;

    // registered ALU that the controller drives
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] h;
        h = $signed(b) >>> 1;
        case (c)
            4'b0000: return a | b;
            4'b0001: return a & b;
            4'b0010: return a ^ b;
            4'b0011: return a << b[4:0];
            4'b0100: return a >> b[4:0];
            4'b0101: return a - b;
            4'b0110: return a + b;
            4'b0111: return ~(a | b);
            4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1010: return a * b;
            4'b1101: return a + h;
            4'b1110: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic alu_ovf(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] r;
        r = alu_f(a, b, c);
        if (c == 4'b0110) return a[31] == b[31] && r[31] != a[31];
        if (c == 4'b0101) return a[31] != b[31] && r[31] != a[31];
        return 1'b0;
    endfunction

    assign alu_c = alu_f(bus.alu_a, bus.alu_b, bus.alu_csig);
    assign bus.alu_z = alu_c == 32'd0;
    assign bus.alu_n = alu_c[31];
    always @(posedge clk) begin
        bus.alu_out <= alu_c;
        bus.alu_v   <= alu_ovf(bus.alu_a, bus.alu_b, bus.alu_csig);
    end

    // instruction-level meaning of each op, independent of ALU codes
    task automatic ref_model(input op_t o, output bit ok, output logic [31:0] r, output bit v);
        logic [31:0] se, ze;
        se = {{16{o.imm[15]}}, o.imm};
        ze = {16'd0, o.imm};
        ok = 1; v = 0; r = 0;
        case (o.op)
            6'h00: case (o.fn)
                6'h20: begin r = o.rs + o.rt; v = o.rs[31] == o.rt[31] && r[31] != o.rs[31]; end
                6'h22: begin r = o.rs - o.rt; v = o.rs[31] != o.rt[31] && r[31] != o.rs[31]; end
                6'h24: r = o.rs & o.rt;
                6'h25: r = o.rs | o.rt;
                6'h26: r = o.rs ^ o.rt;
                6'h27: r = ~(o.rs | o.rt);
                6'h2A: r = ($signed(o.rs) < $signed(o.rt)) ? 1 : 0;
                6'h00: r = o.rt << o.sh;
                6'h02: r = o.rt >> o.sh;
                6'h03: r = $signed(o.rt) >>> o.sh;
                default: ok = 0;
            endcase
            6'h1C: if (o.fn == 6'h02) r = o.rs * o.rt; else ok = 0;
            6'h08: begin r = o.rs + se; v = o.rs[31] == se[31] && r[31] != o.rs[31]; end
            6'h0A: r = ($signed(o.rs) < $signed(se)) ? 1 : 0;
            6'h0C: r = o.rs & ze;
            6'h0D: r = o.rs | ze;
            6'h0E: r = o.rs ^ ze;
            6'h23, 6'h2B: r = o.rs + se;
            default: ok = 0;
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input op_t o, input int hold, input string nm,
                         output logic [31:0] got_data, output logic got_z, output logic got_err);
        bit ok, v;
        logic [31:0] r;
        int lat;
        ref_model(o, ok, r, v);
        @(negedge clk);
        chk({nm, " in_ready idle"}, bus.in_ready, 1);
        pre_a = bus.alu_a; pre_b = bus.alu_b; pre_cs = bus.alu_csig;
        bus.in_opcode = o.op; bus.in_funct = o.fn; bus.in_shamt = o.sh;
        bus.in_rs_val = o.rs; bus.in_rt_val = o.rt; bus.in_imm = o.imm; bus.in_dest = o.dest;
        bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        iss_a = bus.alu_a; iss_b = bus.alu_b; iss_cs = bus.alu_csig;
        lat = 0;
        while (!bus.res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, ok ? 2 : 0);
        got_data = bus.res_data; got_z = bus.res_z; got_err = bus.res_err;
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk({nm, " res_valid"}, bus.res_valid, 1);
            chk({nm, " in_ready busy"}, bus.in_ready, 0);
            chk({nm, " res_data"}, bus.res_data, ok ? r : 32'd0);
            chk({nm, " res_flags zvn"}, {bus.res_z, bus.res_v, bus.res_n},
                {ok && r == 0, ok && v, ok && r[31]});
            chk({nm, " res_err"}, bus.res_err, !ok);
            chk({nm, " res_dest"}, bus.res_dest, o.dest);
        end
        if (!ok) chk({nm, " no alu issue"}, {iss_a, iss_b, iss_cs}, {pre_a, pre_b, pre_cs});
        @(negedge clk);
        bus.res_ready = 1;
        @(posedge clk); #1;
        bus.res_ready = 0;
        chk({nm, " single result"}, bus.res_valid, 0);
        chk({nm, " back to idle"}, bus.in_ready, 1);
    endtask

    vec_t vt[6];
    logic [31:0] gd;
    logic gz, ge;
    op_t ro;
    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h1C, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fns[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h11};

    initial begin
        bus.in_valid = 0; bus.res_ready = 0;
        bus.in_opcode = 0; bus.in_funct = 0; bus.in_shamt = 0;
        bus.in_rs_val = 0; bus.in_rt_val = 0; bus.in_imm = 0; bus.in_dest = 0;
        #1 rst_n = 0;
        #11;
        chk("reset res_valid", bus.res_valid, 0);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset alu_csig", bus.alu_csig, 4'b1011);
        chk("reset alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        chk("reset res_fields", {bus.res_data, bus.res_dest, bus.res_z, bus.res_n, bus.res_v, bus.res_err}, 0);
        @(negedge clk); rst_n = 1;

        vt[0] = '{o: '{op: 6'h00, fn: 6'h20, sh: 0, rs: 5, rt: 7, imm: 0, dest: 5'd3}, exp_data: 12, exp_z: 0, exp_err: 0};
        vt[1] = '{o: '{op: 6'h00, fn: 6'h22, sh: 0, rs: 9, rt: 9, imm: 0, dest: 5'd4}, exp_data: 0, exp_z: 1, exp_err: 0};
        vt[2] = '{o: '{op: 6'h00, fn: 6'h00, sh: 4, rs: 32'hDEAD, rt: 1, imm: 0, dest: 5'd5}, exp_data: 16, exp_z: 0, exp_err: 0};
        vt[3] = '{o: '{op: 6'h23, fn: 6'h00, sh: 0, rs: 32'h100, rt: 0, imm: 16'hFFFC, dest: 5'd6}, exp_data: 32'hFC, exp_z: 0, exp_err: 0};
        vt[4] = '{o: '{op: 6'h3F, fn: 6'h20, sh: 0, rs: 1, rt: 2, imm: 0, dest: 5'd7}, exp_data: 0, exp_z: 0, exp_err: 1};
        vt[5] = '{o: '{op: 6'h0A, fn: 6'h00, sh: 0, rs: 32'hFFFFFFFF, rt: 0, imm: 16'h0001, dest: 5'd31}, exp_data: 1, exp_z: 0, exp_err: 0};
        for (int i = 0; i < 6; i++) begin
            do_op(vt[i].o, 0, $sformatf("vec%0d", i), gd, gz, ge);
            chk($sformatf("vec%0d table data", i), gd, vt[i].exp_data);
            chk($sformatf("vec%0d table z", i), gz, vt[i].exp_z);
            chk($sformatf("vec%0d table err", i), ge, vt[i].exp_err);
            if (i == 1) chk("sub csig in issue", iss_cs, 4'b0101);
            if (i == 2) chk("sll operands", {iss_a, iss_b}, {32'd1, 32'd4});
        end

        do_op('{op: 6'h00, fn: 6'h20, sh: 0, rs: 100, rt: 23, imm: 0, dest: 5'd9}, 5, "backpressure", gd, gz, ge);

        @(negedge clk);
        bus.in_opcode = 6'h00; bus.in_funct = 6'h20; bus.in_rs_val = 3; bus.in_rt_val = 4; bus.in_dest = 5'd2;
        bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("abort res_valid", bus.res_valid, 0);
        chk("abort alu_csig", bus.alu_csig, 4'b1011);
        chk("abort in_ready", bus.in_ready, 1);
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort no result", bus.res_valid, 0);
        end
        do_op('{op: 6'h00, fn: 6'h20, sh: 0, rs: 5, rt: 7, imm: 0, dest: 5'd3}, 0, "after abort", gd, gz, ge);
        chk("after abort data", gd, 12);

        for (int i = 0; i < 150; i++) begin
            ro.op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            ro.fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
            if (ro.op == 6'h1C && $urandom_range(0, 1) == 1) ro.fn = 6'h02;
            ro.sh = 5'($urandom);
            ro.rs = $urandom;
            ro.rt = ($urandom_range(0, 7) == 0) ? ro.rs : $urandom;
            ro.imm = 16'($urandom);
            ro.dest = 5'($urandom);
            do_op(ro, $urandom_range(0, 2), $sformatf("rand%0d", i), gd, gz, ge);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
